// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

  // Controller states: one ADD and one SHIFT per multiplier bit, then one DONE cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mult_state_t;

  // Bit counter must hold values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_addsub.sv
// Combinational N-bit adder/subtractor: y = a + b, or a - b when sub=1.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b - N-bit operands; sub - select subtract; y - N-bit result.
module mult_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_multiplier_n.sv
// Sequential W x W shift-add multiplier (unsigned or two's-complement), product in {A,B}.
// Latency: 2W+2 cycles from accepted start back to IDLE; done pulses one cycle in DONE.
// Backpressure: none queued; start and ld_b are ignored while busy, honoured only in IDLE.
// Ports: clk, reset (sync, active-high); ld_b/start/signed_mode/din control + operand;
//        a_out/b_out/x_out product registers; busy (not IDLE); done (one-cycle pulse).
module seq_multiplier_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_b,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] din,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic         x_out,
  output logic         busy,
  output logic         done
);

  import mult_pkg::*;

  localparam int CW = cnt_width(W);

  mult_state_t   state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic          x_q, x_d;
  logic          signed_q, signed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    ext_a, ext_s, sum;
  logic          last_bit;
  logic          sub;

  // In signed mode X always equals A[W-1] between steps, so sign-extending A
  // reproduces the full {X,A} value; in unsigned mode X is the carry and A is
  // zero-extended.
  assign ext_a    = signed_q ? {a_q[W-1], a_q} : {1'b0, a_q};
  assign ext_s    = signed_q ? {s_q[W-1], s_q} : {1'b0, s_q};
  assign last_bit = (cnt_q == CW'(W - 1));
  // The multiplier MSB carries weight -2^(W-1) in two's complement.
  assign sub      = signed_q & last_bit;

  mult_addsub #(.N(W + 1)) u_addsub (
    .a   (ext_a),
    .b   (ext_s),
    .sub (sub),
    .y   (sum)
  );

  // All state in one clocked process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      x_q      <= 1'b0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      x_q      <= x_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; ld_b wins over start in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!ld_b && start) state_d = ST_ADD;
      ST_ADD:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = last_bit ? ST_DONE : ST_ADD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    x_d      = x_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_b) begin
          b_d = din;
          a_d = '0;
          x_d = 1'b0;
        end else if (start) begin
          s_d      = din;
          signed_d = signed_mode;
          a_d      = '0;
          x_d      = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_ADD: begin
        if (b_q[0]) {x_d, a_d} = sum;
      end
      ST_SHIFT: begin
        // Arithmetic shift keeps X in signed mode; unsigned shifts in zero.
        x_d   = signed_q ? x_q : 1'b0;
        a_d   = {x_q, a_q[W-1:1]};
        b_d   = {a_q[0], b_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign x_out = x_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Self-checking bench for seq_multiplier_n (W=8 and W=16 instances).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seq_multiplier_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_b, start, signed_mode;
  logic [7:0]  din;
  logic [7:0]  a8, b8;
  logic        x8, busy8, done8;
  logic        ld_b16, start16, sm16;
  logic [15:0] din16;
  logic [15:0] a16, b16;
  logic        x16, busy16, done16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier_n #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .ld_b(ld_b), .start(start),
    .signed_mode(signed_mode), .din(din),
    .a_out(a8), .b_out(b8), .x_out(x8), .busy(busy8), .done(done8)
  );

  seq_multiplier_n #(.W(16)) dut16 (
    .clk(clk), .reset(reset), .ld_b(ld_b16), .start(start16),
    .signed_mode(sm16), .din(din16),
    .a_out(a16), .b_out(b16), .x_out(x16), .busy(busy16), .done(done16)
  );

  typedef struct {
    logic [7:0] b;
    logic [7:0] s;
    bit         sgn;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Exact product of two w-bit operands, as a 2w-bit pattern.
  function automatic logic [63:0] ref_mul(input logic [31:0] s, input logic [31:0] b,
                                          input bit sgn, input int w);
    longint m, sv, bv;
    m  = (longint'(1) << w) - 1;
    sv = longint'(s) & m;
    bv = longint'(b) & m;
    if (sgn) begin
      if (sv >= (longint'(1) << (w - 1))) sv -= (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv -= (longint'(1) << w);
    end
    return 64'((sv * bv) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic do_ld(input logic [7:0] v);
    ld_b = 1'b1;
    din  = v;
    tick();
    ld_b = 1'b0;
    din  = 8'($urandom);
    chk("ld_b_value", 64'(b8), 64'(v));
    chk("ld_a_clear", 64'(a8), 64'(0));
  endtask

  // Start a multiply and wait for done; optionally toggle ld_b/start/din while busy.
  task automatic run_mul8(input logic [7:0] s, input bit sgn, input bit disturb, output int edges);
    start       = 1'b1;
    din         = s;
    signed_mode = sgn;
    tick();
    edges       = 1;
    start       = 1'b0;
    signed_mode = 1'($urandom);
    din         = 8'($urandom);
    chk("busy_after_start", 64'(busy8), 64'(1));
    while (!done8 && edges < 100) begin
      if (disturb) begin
        ld_b  = 1'($urandom);
        start = 1'($urandom);
        din   = 8'($urandom);
      end
      tick();
      edges++;
    end
    ld_b  = 1'b0;
    start = 1'b0;
    chk("done_seen", 64'(done8), 64'(1));
    chk("done_edges", 64'(edges), 64'(17));
  endtask

  vec_t        tbl[5];
  int          e, pulses;
  logic [63:0] exp;
  logic [7:0]  rb, rs, ea, eb;
  bit          rsg;

  initial begin
    tbl[0] = '{b: 8'h07, s: 8'h3B, sgn: 1'b1, ea: 8'h01, eb: 8'h9D};
    tbl[1] = '{b: 8'h07, s: 8'hC5, sgn: 1'b1, ea: 8'hFE, eb: 8'h63};
    tbl[2] = '{b: 8'hC5, s: 8'h07, sgn: 1'b1, ea: 8'hFE, eb: 8'h63};
    tbl[3] = '{b: 8'hF9, s: 8'hC5, sgn: 1'b1, ea: 8'h01, eb: 8'h9D};
    tbl[4] = '{b: 8'hFF, s: 8'hFF, sgn: 1'b0, ea: 8'hFE, eb: 8'h01};

    reset = 1'b1; ld_b = 1'b0; start = 1'b0; signed_mode = 1'b0; din = 8'h00;
    ld_b16 = 1'b0; start16 = 1'b0; sm16 = 1'b0; din16 = 16'h0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_a", 64'(a8), 64'(0));
    chk("rst_b", 64'(b8), 64'(0));
    chk("rst_x", 64'(x8), 64'(0));
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst16_busy", 64'(busy16), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      do_ld(tbl[i].b);
      run_mul8(tbl[i].s, tbl[i].sgn, 1'b0, e);
      chk("tbl_a", 64'(a8), 64'(tbl[i].ea));
      chk("tbl_b", 64'(b8), 64'(tbl[i].eb));
      chk("tbl_x", 64'(x8), tbl[i].sgn ? 64'(tbl[i].ea[7]) : 64'(0));
      tick();
      chk("done_one_cycle", 64'(done8), 64'(0));
      chk("idle_after_done", 64'(busy8), 64'(0));
    end

    // Result holds in IDLE while din wanders.
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      tick();
      chk("hold_a", 64'(a8), 64'(8'hFE));
      chk("hold_b", 64'(b8), 64'(8'h01));
    end

    // ld_b beats start in the same IDLE cycle; start is not queued.
    ld_b = 1'b1; start = 1'b1; din = 8'h55; signed_mode = 1'b1;
    tick();
    ld_b = 1'b0; start = 1'b0; din = 8'h00;
    chk("prio_busy", 64'(busy8), 64'(0));
    chk("prio_b", 64'(b8), 64'(8'h55));
    chk("prio_a", 64'(a8), 64'(0));
    chk("prio_x", 64'(x8), 64'(0));
    tick();
    chk("prio_no_queue", 64'(busy8), 64'(0));

    // ld_b/start pulsed while busy must not disturb the product.
    do_ld(8'h07);
    run_mul8(8'h3B, 1'b1, 1'b1, e);
    chk("disturb_a", 64'(a8), 64'(8'h01));
    chk("disturb_b", 64'(b8), 64'(8'h9D));
    tick();

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      rs  = 8'($urandom);
      rsg = 1'($urandom);
      exp = ref_mul(32'(rs), 32'(rb), rsg, 8);
      ea  = exp[15:8];
      eb  = exp[7:0];
      do_ld(rb);
      run_mul8(rs, rsg, (i % 3) == 0, e);
      chk("rnd_a", 64'(a8), 64'(ea));
      chk("rnd_b", 64'(b8), 64'(eb));
      chk("rnd_x", 64'(x8), rsg ? 64'(ea[7]) : 64'(0));
      tick();
    end

    // Chained signed multiplies with start held high.
    do_ld(8'hFF);
    start = 1'b1; din = 8'hFF; signed_mode = 1'b1;
    pulses = 0;
    e = 0;
    while (pulses < 5 && e < 400) begin
      tick();
      e++;
      if (done8) begin
        pulses++;
        chk("chain_b", 64'(b8), (pulses % 2) ? 64'(8'h01) : 64'(8'hFF));
        chk("chain_a", 64'(a8), (pulses % 2) ? 64'(8'h00) : 64'(8'hFF));
        if (pulses == 5) start = 1'b0;
      end
    end
    chk("chain_pulses", 64'(pulses), 64'(5));
    chk("chain_edges", 64'(e), 64'(89));
    tick();
    chk("chain_stop", 64'(busy8), 64'(0));
    chk("chain_final_a", 64'(a8), 64'(0));
    chk("chain_final_b", 64'(b8), 64'(8'h01));

    // Reset mid-operation (cycle after 5th ADD), with ld_b in the same cycle.
    do_ld(8'h07);
    start = 1'b1; din = 8'h3B; signed_mode = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("mid_busy", 64'(busy8), 64'(1));
    reset = 1'b1; ld_b = 1'b1; din = 8'h77;
    tick();
    reset = 1'b0; ld_b = 1'b0;
    chk("midrst_a", 64'(a8), 64'(0));
    chk("midrst_b", 64'(b8), 64'(0));
    chk("midrst_x", 64'(x8), 64'(0));
    chk("midrst_busy", 64'(busy8), 64'(0));
    chk("midrst_done", 64'(done8), 64'(0));

    // W=16 unsigned corner.
    ld_b16 = 1'b1; din16 = 16'hFFFF;
    tick();
    ld_b16 = 1'b0;
    start16 = 1'b1; sm16 = 1'b0;
    tick();
    e = 1;
    start16 = 1'b0; din16 = 16'h1234;
    while (!done16 && e < 200) begin
      tick();
      e++;
    end
    chk("w16_done_seen", 64'(done16), 64'(1));
    chk("w16_edges", 64'(e), 64'(33));
    chk("w16_a", 64'(a16), 64'(16'hFFFE));
    chk("w16_b", 64'(b16), 64'(16'h0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
